// File: rtl/fpu_seq_if.sv
// Handshaked operand/result bus for fpu_seq: operands in (valid/ready), result and flags out (valid/ready).
interface fpu_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
);
    localparam int OP_W  = EXP_W + MAN_W;
    localparam int RES_W = EXP_W + 2 * MAN_W;

    logic [OP_W-1:0]  opA;
    logic [OP_W-1:0]  opB;
    logic [1:0]       opcode;
    logic             in_valid;
    logic             in_ready;
    logic [RES_W-1:0] result;
    logic             overflow_flag;
    logic             ok_exp_flag;
    logic             illegal_flag;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output opA, opB, opcode, in_valid, out_ready,
        input  in_ready, result, overflow_flag, ok_exp_flag, illegal_flag, out_valid
    );

    modport slave (
        input  opA, opB, opcode, in_valid, out_ready,
        output in_ready, result, overflow_flag, ok_exp_flag, illegal_flag, out_valid
    );
endinterface

// File: rtl/fpu_seq.sv
// Sequential FPU on {exp, two's-complement mantissa} operands: aligned add/sub and
// a shift-add signed multiplier, one operation in flight at a time.
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic     clk,
    input  logic     reset,
    fpu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(MAN_W);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_MUL, S_FIX, S_DONE} state_t;

    state_t state, next_state;

    logic [EXP_W-1:0]        exp_a, exp_b, emax;
    logic signed [MAN_W-1:0] man_a, man_b;
    logic                    is_sub;
    logic [MAN_W-1:0]        mag_a, mag_b;
    logic                    sgn;
    logic [CNT_W-1:0]        cnt;
    logic [2*MAN_W-1:0]      acc;
    logic signed [MAN_W:0]   al_a, al_b;

    logic                    accept;
    logic                    a_big;
    logic [EXP_W-1:0]        d;
    logic signed [MAN_W-1:0] sh_a, sh_b;
    logic signed [MAN_W:0]   sum;
    logic [2*MAN_W-1:0]      prod;
    logic [EXP_W:0]          esum;

    function automatic logic signed [MAN_W-1:0] asr(input logic signed [MAN_W-1:0] m,
                                                     input logic [EXP_W-1:0] sh);
        if (32'(sh) >= MAN_W) return {MAN_W{m[MAN_W-1]}};
        return m >>> sh;
    endfunction

    function automatic logic [MAN_W-1:0] mag(input logic signed [MAN_W-1:0] m);
        // -2^(MAN_W-1) negates to itself, which read unsigned is exactly its magnitude
        return m[MAN_W-1] ? MAN_W'(-m) : MAN_W'(m);
    endfunction

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        a_big = (exp_a >= exp_b);
        d     = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
        sh_a  = a_big ? man_a : asr(man_a, d);
        sh_b  = a_big ? asr(man_b, d) : man_b;
        sum   = al_a + al_b;
        prod  = sgn ? -acc : acc;
        esum  = {1'b0, exp_a} + {1'b0, exp_b};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) begin
                case (bus.opcode)
                    2'b10:   next_state = S_MUL;
                    2'b11:   next_state = S_DONE;
                    default: next_state = S_ALIGN;
                endcase
            end
            S_ALIGN:  next_state = S_ADDSUB;
            S_ADDSUB: next_state = S_DONE;
            S_MUL:    if (cnt == CNT_W'(MAN_W - 1)) next_state = S_FIX;
            S_FIX:    next_state = S_DONE;
            S_DONE:   if (bus.out_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_a <= '0; exp_b <= '0; emax <= '0;
            man_a <= '0; man_b <= '0; is_sub <= 1'b0;
            mag_a <= '0; mag_b <= '0; sgn <= 1'b0;
            cnt   <= '0; acc <= '0;
            al_a  <= '0; al_b <= '0;
            bus.result        <= '0;
            bus.overflow_flag <= 1'b0;
            bus.ok_exp_flag   <= 1'b0;
            bus.illegal_flag  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    exp_a  <= bus.opA[EXP_W+MAN_W-1:MAN_W];
                    exp_b  <= bus.opB[EXP_W+MAN_W-1:MAN_W];
                    man_a  <= bus.opA[MAN_W-1:0];
                    man_b  <= bus.opB[MAN_W-1:0];
                    is_sub <= bus.opcode[0];
                    mag_a  <= mag(bus.opA[MAN_W-1:0]);
                    mag_b  <= mag(bus.opB[MAN_W-1:0]);
                    sgn    <= bus.opA[MAN_W-1] ^ bus.opB[MAN_W-1];
                    cnt    <= '0;
                    acc    <= '0;
                    if (bus.opcode == 2'b11) begin
                        bus.result        <= '0;
                        bus.overflow_flag <= 1'b0;
                        bus.ok_exp_flag   <= 1'b0;
                        bus.illegal_flag  <= 1'b1;
                    end
                end
                S_ALIGN: begin
                    emax <= a_big ? exp_a : exp_b;
                    al_a <= {sh_a[MAN_W-1], sh_a};
                    // one extra bit so negating -2^(MAN_W-1) cannot wrap
                    al_b <= is_sub ? -{sh_b[MAN_W-1], sh_b} : {sh_b[MAN_W-1], sh_b};
                end
                S_ADDSUB: begin
                    bus.result        <= {emax, {(MAN_W-1){sum[MAN_W]}}, sum};
                    bus.overflow_flag <= sum[MAN_W] ^ sum[MAN_W-1];
                    bus.ok_exp_flag   <= 1'b1;
                    bus.illegal_flag  <= 1'b0;
                end
                S_MUL: begin
                    if (mag_b[cnt]) acc <= acc + ({{MAN_W{1'b0}}, mag_a} << cnt);
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    bus.result        <= {esum[EXP_W-1:0], prod};
                    bus.overflow_flag <= 1'b0;
                    bus.ok_exp_flag   <= ~esum[EXP_W];
                    bus.illegal_flag  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_seq.sv
// Table-driven scoreboard bench for fpu_seq at default parameters.
module tb_fpu_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 24;

    logic clk = 1'b0;
    logic reset;

    fpu_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fpu_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [63:0] res;
        logic        ovf;
        logic        ok;
        logic        ill;
        int          lat;   // edges after the accept edge until out_valid is seen
    } vec_t;

    vec_t tbl[13];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int hold);
        vec_t e;
        int   lat;
        logic busy_ok;
        @(negedge clk);
        chk({v.name, " in_ready_idle"}, 64'(bus.in_ready), 64'(1));
        bus.opA = v.a; bus.opB = v.b; bus.opcode = v.op;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        sb.push_back(v);
        @(posedge clk); #1;
        // scramble operands after accept; under backpressure keep offering them
        bus.opA = $urandom; bus.opB = $urandom;
        bus.in_valid = (hold > 0);
        lat = 0; busy_ok = 1'b1;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({v.name, " out_valid_seen"}, 64'(bus.out_valid), 64'(1));
        chk({v.name, " in_ready_busy"}, 64'(busy_ok), 64'(1));
        e = sb.pop_front();
        chk({e.name, " latency"}, 64'(lat), 64'(e.lat));
        for (int i = 0; i < hold; i++) begin
            chk({e.name, " hold_result"}, 64'(bus.result), e.res);
            chk({e.name, " hold_in_ready"}, 64'(bus.in_ready), 64'(0));
            chk({e.name, " hold_out_valid"}, 64'(bus.out_valid), 64'(1));
            @(negedge clk);
        end
        chk({e.name, " result"}, 64'(bus.result), e.res);
        chk({e.name, " overflow"}, 64'(bus.overflow_flag), 64'(e.ovf));
        chk({e.name, " ok_exp"}, 64'(bus.ok_exp_flag), 64'(e.ok));
        chk({e.name, " illegal"}, 64'(bus.illegal_flag), 64'(e.ill));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({e.name, " out_valid_drop"}, 64'(bus.out_valid), 64'(0));
        chk({e.name, " in_ready_back"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        logic orphan;
        tbl[0]  = '{"add_eq",     32'h04000004, 32'h04000003, 2'b00, 64'h04000000000007, 1'b0, 1'b1, 1'b0, 2};
        tbl[1]  = '{"add_align",  32'h04000010, 32'h02000008, 2'b00, 64'h04000000000012, 1'b0, 1'b1, 1'b0, 2};
        tbl[2]  = '{"sub_neg",    32'h01000005, 32'h01000007, 2'b01, 64'h01FFFFFFFFFFFE, 1'b0, 1'b1, 1'b0, 2};
        tbl[3]  = '{"add_ovf",    32'h007FFFFF, 32'h00000001, 2'b00, 64'h00000000800000, 1'b1, 1'b1, 1'b0, 2};
        tbl[4]  = '{"sub_ovf",    32'h00800000, 32'h00000001, 2'b01, 64'h00FFFFFF7FFFFF, 1'b1, 1'b1, 1'b0, 2};
        tbl[5]  = '{"sub_bigd",   32'h20000005, 32'h00FFFFF0, 2'b01, 64'h20000000000006, 1'b0, 1'b1, 1'b0, 2};
        tbl[6]  = '{"add_trunc",  32'h00FFFFF9, 32'h01000001, 2'b00, 64'h01FFFFFFFFFFFD, 1'b0, 1'b1, 1'b0, 2};
        tbl[7]  = '{"mul_neg",    32'h01000003, 32'h02FFFFFE, 2'b10, 64'h03FFFFFFFFFFFA, 1'b0, 1'b1, 1'b0, MAN_W + 1};
        tbl[8]  = '{"mul_expov",  32'hC0000001, 32'h80000001, 2'b10, 64'h40000000000001, 1'b0, 1'b0, 1'b0, MAN_W + 1};
        tbl[9]  = '{"mul_minmin", 32'h00800000, 32'h00800000, 2'b10, 64'h00400000000000, 1'b0, 1'b1, 1'b0, MAN_W + 1};
        tbl[10] = '{"mul_zero",   32'h00800000, 32'h00000000, 2'b10, 64'h00000000000000, 1'b0, 1'b1, 1'b0, MAN_W + 1};
        tbl[11] = '{"mul_negneg", 32'h01FFFFFD, 32'h01FFFFFB, 2'b10, 64'h0200000000000F, 1'b0, 1'b1, 1'b0, MAN_W + 1};
        // illegal finishes on the accept edge itself
        tbl[12] = '{"illegal",    32'h12345678, 32'h9ABCDEF0, 2'b11, 64'h00000000000000, 1'b0, 1'b0, 1'b1, 0};

        reset = 1'b1;
        bus.opA = '0; bus.opB = '0; bus.opcode = 2'b00;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst result", 64'(bus.result), 64'(0));
        chk("rst flags", 64'({bus.overflow_flag, bus.ok_exp_flag, bus.illegal_flag}), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_op(tbl[i], 0);

        // backpressure on a finished add, then on an illegal op
        run_op(tbl[1], 10);
        run_op(tbl[12], 3);

        // reset mid-multiply (count=10) while a new request is offered
        @(negedge clk);
        bus.opA = 32'h01000003; bus.opB = 32'h02FFFFFE; bus.opcode = 2'b10; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.opA = 32'h04000004; bus.opB = 32'h04000003; bus.opcode = 2'b00; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.in_valid = 1'b0;
        chk("abort in_ready", 64'(bus.in_ready), 64'(1));
        chk("abort out_valid", 64'(bus.out_valid), 64'(0));
        chk("abort result", 64'(bus.result), 64'(0));
        chk("abort flags", 64'({bus.overflow_flag, bus.ok_exp_flag, bus.illegal_flag}), 64'(0));
        orphan = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) orphan = 1'b1;
        end
        chk("abort no_result_or_accept", 64'(orphan), 64'(0));
        run_op(tbl[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
